// File: rtl/serial_byte_rx.sv
// Serial byte receiver: 2-flop sync, start/data/stop deframer, show-ahead FIFO.
// Define SERIAL_RX_PARITY_EN to add an even-parity bit and the parity_err flag.
module serial_byte_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 rd_en,
    input  logic                 clr_err,
    output logic [DATA_BITS-1:0] dout,
    output logic                 valid,
    output logic                 overrun,
`ifdef SERIAL_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, rxs_q, rxs_prev_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 push_q, push_d;
    logic [DATA_BITS-1:0] push_data_q, push_data_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 ferr_ev;
    logic                 tick;
`ifdef SERIAL_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 par_err_q, par_err_d;
    logic                 perr_ev;
`endif

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_q, rd_q;
    logic                 empty, full, pop, wr_ok, ovf_ev;

    // rxs is the only view of the line the deframer ever uses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= rxd;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
        end
    end

    assign tick = (cnt_q == FULL_M1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        bit_d       = bit_q;
        sh_d        = sh_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        ferr_ev     = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_bad_d   = par_bad_q;
        perr_ev     = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rxs_prev_q && !rxs_q) begin
                    state_d = S_START;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_d = '0;
                    sh_d  = {rxs_q, sh_q[DATA_BITS-1:1]};
                    bit_d = bit_q + BW'(1);
                    if (bit_q == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    cnt_d     = '0;
                    par_bad_d = ^{sh_q, rxs_q};
                    perr_ev   = ^{sh_q, rxs_q};
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (!rxs_q) begin
                        ferr_ev = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                    end else if (!par_bad_q) begin
`else
                    end else begin
`endif
                        push_d      = 1'b1;
                        push_data_d = sh_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // set wins over a coincident clear
    assign frame_err_d = (frame_err_q & ~clr_err) | ferr_ev;
    assign overrun_d   = (overrun_q & ~clr_err) | ovf_ev;
`ifdef SERIAL_RX_PARITY_EN
    assign par_err_d   = (par_err_q & ~clr_err) | perr_ev;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            sh_q        <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
            par_err_q <= par_err_d;
        end
    end
    assign parity_err = par_err_q;
`endif

    // pointer MSB distinguishes full from empty when the indices match
    assign empty  = (wr_q == rd_q);
    assign full   = (wr_q[AW] != rd_q[AW]) &&
                    (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop    = rd_en && !empty;
    assign wr_ok  = push_q && (!full || pop);
    assign ovf_ev = push_q && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_ok) wr_q <= wr_q + PW'(1);
            if (pop)   rd_q <= rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_q[AW-1:0]] <= push_data_q;
    end

    assign valid     = !empty;
    assign dout      = empty ? '0 : mem[rd_q[AW-1:0]];
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_byte_rx.sv
// Bench for serial_byte_rx: queue-based receive model plus directed frames.
// Build with SERIAL_RX_PARITY_EN to exercise the parity variant.
module tb_serial_byte_rx;

    localparam int CPB   = 16;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
`ifdef SERIAL_RX_PARITY_EN
    localparam int PB    = 1;
    localparam int LAT_LIT = 172;
`else
    localparam int PB    = 0;
    localparam int LAT_LIT = 156;
`endif
    // rxd is driven at a negedge; two sync flops plus one detect cycle
    // put the FSM start edge 3 edges later, then the bit-time arithmetic.
    localparam int STOP_OFF = CPB / 2 + (DB + PB + 1) * CPB;
    localparam int FERR_DLY = 3 + STOP_OFF;
    localparam int PUSH_DLY = 4 + STOP_OFF;
    localparam int PERR_DLY = 3 + CPB / 2 + (DB + 1) * CPB;

    logic       clk = 1'b0;
    logic       rst, rxd, rd_en, clr_err;
    logic [7:0] dout;
    logic       valid, overrun, frame_err;
`ifdef SERIAL_RX_PARITY_EN
    logic       parity_err;
`endif

    always #5 clk = ~clk;

    serial_byte_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .dout      (dout),
        .valid     (valid),
        .overrun   (overrun),
`ifdef SERIAL_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .frame_err (frame_err)
    );

    typedef struct {
        int unsigned at;
        int          kind;
        logic [7:0]  d;
    } ev_t;

    int unsigned cyc = 0;
    logic [7:0]  mq[$];
    ev_t         evq[$];
    logic        m_ov = 1'b0, m_fe = 1'b0, m_pe = 1'b0;
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: FIFO is a queue, frame outcomes arrive as timed events
    always @(posedge clk) begin
        logic pop, full, ovev, feev, peev;
        cyc++;
        if (rst) begin
            mq.delete();
            evq.delete();
            m_ov = 1'b0;
            m_fe = 1'b0;
            m_pe = 1'b0;
        end else begin
            pop  = rd_en && (mq.size() != 0);
            full = (mq.size() == DEPTH);
            ovev = 1'b0;
            feev = 1'b0;
            peev = 1'b0;
            if (pop) void'(mq.pop_front());
            for (int i = evq.size() - 1; i >= 0; i--) begin
                if (evq[i].at == cyc) begin
                    case (evq[i].kind)
                        0: if (full && !pop) ovev = 1'b1;
                           else mq.push_back(evq[i].d);
                        1: feev = 1'b1;
                        default: peev = 1'b1;
                    endcase
                    evq.delete(i);
                end
            end
            m_ov = (m_ov && !clr_err) || ovev;
            m_fe = (m_fe && !clr_err) || feev;
            m_pe = (m_pe && !clr_err) || peev;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", valid, mq.size() != 0);
            chk("dout", dout, (mq.size() != 0) ? mq[0] : 8'h00);
            chk("overrun", overrun, m_ov);
            chk("frame_err", frame_err, m_fe);
`ifdef SERIAL_RX_PARITY_EN
            chk("parity_err", parity_err, m_pe);
`endif
        end
    end

    task automatic tx(input logic [7:0] b, input logic stop, input logic badpar);
        int unsigned c;
        logic        par;
        logic        pbad;
        c    = cyc;
        par  = (^b) ^ badpar;
        pbad = (PB == 1) && badpar;
        if (pbad) evq.push_back('{c + PERR_DLY, 2, 8'h00});
        if (!stop) evq.push_back('{c + FERR_DLY, 1, 8'h00});
        else if (!pbad) evq.push_back('{c + PUSH_DLY, 0, b});
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (PB == 1) begin
            rxd = par;
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic pulse_rd(input int n);
        repeat (n) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr(input int n);
        repeat (n) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; rxd = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_err", frame_err, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // single byte latency
        k = 0;
        fork
            tx(8'hA5, 1'b1, 1'b0);
            begin
                while (!valid && k < 400) begin
                    @(negedge clk);
                    k++;
                end
            end
        join
        chk("a5_latency", k, LAT_LIT);
        chk("a5_dout", dout, 8'hA5);
        pulse_rd(0);
        chk("a5_popped", valid, 0);

        // five frames into a four-deep FIFO
        for (int b = 1; b <= 5; b++) tx(8'(b), 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("ovr_set", overrun, 1);
        chk("ovr_head", dout, 8'h01);
        pulse_clr(0);
        chk("ovr_clr", overrun, 0);

        // full FIFO, pop coincident with push
        fork
            tx(8'h06, 1'b1, 1'b0);
            pulse_rd(PUSH_DLY - 1);
        join
        chk("fullpp_ovr", overrun, 0);
        chk("fullpp_head", dout, 8'h02);
        for (int b = 2; b <= 4; b++) begin
            chk("drain", dout, b);
            pulse_rd(0);
        end
        chk("tail06", dout, 8'h06);

        // single entry, pop coincident with push
        fork
            tx(8'h11, 1'b1, 1'b0);
            pulse_rd(PUSH_DLY - 1);
        join
        chk("onepp_valid", valid, 1);
        chk("onepp_dout", dout, 8'h11);
        pulse_rd(0);
        chk("onepp_empty", valid, 0);

        // short low glitch
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_valid", valid, 0);
        chk("glitch_ferr", frame_err, 0);
        tx(8'h3C, 1'b1, 1'b0);
        chk("after_glitch", dout, 8'h3C);
        pulse_rd(0);

        // framing error, clear, recovery, set-wins
        tx(8'h55, 1'b0, 1'b0);
        chk("ferr_set", frame_err, 1);
        chk("ferr_novalid", valid, 0);
        pulse_clr(0);
        chk("ferr_clr", frame_err, 0);
        tx(8'hFF, 1'b1, 1'b0);
        chk("ff_dout", dout, 8'hFF);
        fork
            tx(8'h12, 1'b0, 1'b0);
            pulse_clr(FERR_DLY - 1);
        join
        chk("ferr_setwins", frame_err, 1);
        chk("ferr_discard", dout, 8'hFF);

        // reset in the middle of the data bits of 0x81
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
        rxd = 1'b0;
        repeat (2 * CPB + 4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_ovr", overrun, 0);
        chk("mid_rst_ferr", frame_err, 0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        tx(8'h7E, 1'b1, 1'b0);
        chk("post_rst_valid", valid, 1);
        chk("post_rst_dout", dout, 8'h7E);
        pulse_rd(0);

`ifdef SERIAL_RX_PARITY_EN
        tx(8'h07, 1'b1, 1'b1);
        chk("perr_set", parity_err, 1);
        chk("perr_discard", valid, 0);
        pulse_clr(0);
        chk("perr_clr", parity_err, 0);
        tx(8'h07, 1'b1, 1'b0);
        chk("par_good", dout, 8'h07);
        pulse_rd(0);
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
